m_store_buffer: RTL and testbench
=================================

# m_store_buffer

Memory-stage store path for the pipelined MIPS core: the write-side counterpart of the load data extender. It turns `sw`/`sh`/`sb` requests into word-aligned address, byte-enable and lane-replicated write data, and queues them in an in-order FIFO. It drains the FIFO to data memory over a req/ack handshake. It also flags misaligned stores and tells the hazard unit when a load hits a word with a pending store.

## Interface
Parameters:
- `DEPTH`, 2: number of store-buffer entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `st_valid`  in  1  store request from M stage this cycle.
- `st_op`  in  2  2'b00 none, 2'b01 sw, 2'b10 sh, 2'b11 sb.
- `st_addr`  in  32  byte address from ALU.
- `st_data`  in  32  raw rt value.
- `st_ready`  out  1  buffer can accept; = !full.
- `mem_req`  out  1  head entry valid; = !empty.
- `mem_addr`  out  32  head word address, bits [1:0] = 0.
- `mem_byteen`  out  4  head byte enables.
- `mem_wdata`  out  32  head write data, lane-replicated.
- `mem_ack`  in  1  memory accepted head this cycle.
- `ld_check`  in  1  a load is in M stage this cycle.
- `ld_addr`  in  32  load byte address.
- `ld_stall`  out  1  load word matches a valid buffered store.
- `align_err`  out  1  registered one-cycle pulse for a misaligned store.
- `bad_addr`  out  32  address of most recent misaligned store.
- `count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Accept condition: `st_valid && st_op!=0 && !misaligned && st_ready`. An accepted request is written at the tail and the tail pointer advances.
- Misaligned:
  - sw when `st_addr[1:0]!=0`.
  - sh when `st_addr[0]!=0`.
  - sb never.
  - A misaligned store is never enqueued. Next cycle `align_err`=1 and `bad_addr`=`st_addr`. `align_err` is checked irrespective of `st_ready`.
- Byte enables:
  - sw: 4'b1111.
  - sh: `st_addr[1]` ? 4'b1100 : 4'b0011.
  - sb: 4'b0001 << `st_addr[1:0]`.
- Write data:
  - sw: `st_data`.
  - sh: {2{`st_data[15:0]`}}.
  - sb: {4{`st_data[7:0]`}}.
- Entries store word address, byte enables and data. The outputs `mem_*` are driven from the head entry. When `mem_req`=0, `mem_*` are driven to 0.
- Pop condition: `mem_req && mem_ack`. The head pointer advances and `count` decrements. `mem_ack` while empty is ignored.
- Drain order is strictly FIFO. Stores to the same word are never merged.
- Full: `st_ready`=0, and any request that cycle is dropped. The pipeline must stall and re-present it. A pop in the same cycle does not enable an enqueue; `st_ready` depends only on registered `count`.
- Simultaneous enqueue and pop with 0<count<DEPTH: `count` is unchanged and both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decoded from `count`.
- `ld_stall` = `ld_check` AND some valid entry has word address == {`ld_addr[31:2]`,2'b00}. It is combinational from registered state. The store being enqueued the same cycle is not compared, because it is younger than the load.

## Timing
- Reset values:
  - `count`=0, pointers=0.
  - `mem_req`=0, `mem_addr`=0, `mem_byteen`=0, `mem_wdata`=0.
  - `st_ready`=1, `ld_stall`=0, `align_err`=0, `bad_addr`=0.
- Reset mid-drain discards all pending entries; there is no memory write after reset.
- Enqueue-to-`mem_req` latency: 1 cycle when empty.
- `mem_*` hold stable until the `mem_ack` cycle. The next entry appears the cycle after the ack.
- Maximum throughput: one store per cycle with `mem_ack` held high.
- `align_err` is high for exactly one cycle per misaligned request. It stays high on back-to-back misaligned requests, and `bad_addr` updates each time.

## Test plan
- **sb/sh/sw lanes:** after reset, sb addr 0x13 data 0x000000AB, then `mem_ack`=1. Require next cycle `mem_req`=1, `mem_addr`=0x10, `mem_byteen`=4'b1000, `mem_wdata`=0xABABABAB. Repeat for sh 0x12 data 0x1234 (4'b1100, 0x12341234) and sw 0x20 (4'b1111, data unchanged).
- **Misalignment:** sw 0x21, then sh 0x33. Require no enqueue (`count`=0), `align_err`=1 on both following cycles, and `bad_addr` = 0x21, then 0x33.
- **Full/backpressure (DEPTH=2):** enqueue 3 stores with `mem_ack`=0. Require `count`=2 and `st_ready`=0, with the third dropped. Ack once: `count`=1. Then re-present the third: it is accepted, and the drain order is 1, 2, 3.
- **Simultaneous enqueue and pop:** at `count`=1, enqueue while `mem_ack`=1. Require `count` stays 1, the new entry at the head next cycle, and correct data across pointer wrap over 8 iterations.
- **Load conflict:** buffer holds sw 0x40. Load at 0x42 gives `ld_stall`=1; load at 0x44 gives 0. After the 0x40 entry is acked, a load at 0x42 gives 0.
- **Reset mid-drain:** `count`=2 with `mem_req`=1, then assert `reset` one cycle. Require next cycle `mem_req`=0, `count`=0, `st_ready`=1, `align_err`=0.

Source files
------------

// File: rtl/m_store_buffer.sv
// In-order store buffer for the MIPS memory stage: formats sw/sh/sb into word
// address, byte enables and lane-replicated data, then drains them over req/ack.
module m_store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [1:0]             st_op,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  output logic                   st_ready,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  output logic [3:0]             mem_byteen,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic                   ld_check,
  input  logic [31:0]            ld_addr,
  output logic                   ld_stall,
  output logic                   align_err,
  output logic [31:0]            bad_addr,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [29:0]   waddr_mem [DEPTH];
  logic [3:0]    be_mem    [DEPTH];
  logic [31:0]   data_mem  [DEPTH];

  logic [AW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          align_err_reg;
  logic [31:0]   bad_addr_reg;

  logic          misaligned, st_req, enq, pop;
  logic [3:0]    enq_be;
  logic [31:0]   enq_data;
  logic [DEPTH-1:0] hit;
  logic          unused_ld_lsbs;

  always_comb begin
    misaligned = 1'b0;
    enq_be     = 4'b0000;
    enq_data   = 32'h0;
    case (st_op)
      2'b01: begin
        misaligned = (st_addr[1:0] != 2'b00);
        enq_be     = 4'b1111;
        enq_data   = st_data;
      end
      2'b10: begin
        misaligned = st_addr[0];
        enq_be     = st_addr[1] ? 4'b1100 : 4'b0011;
        enq_data   = {2{st_data[15:0]}};
      end
      2'b11: begin
        enq_be     = 4'b0001 << st_addr[1:0];
        enq_data   = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  assign st_req   = st_valid && (st_op != 2'b00);
  assign st_ready = (count_reg != FULL_COUNT);
  assign mem_req  = (count_reg != '0);
  assign enq      = st_req && !misaligned && st_ready;
  assign pop      = mem_req && mem_ack;

  always_comb begin
    count_next = count_reg;
    case ({enq, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      align_err_reg <= 1'b0;
      bad_addr_reg  <= 32'h0;
    end else begin
      count_reg     <= count_next;
      if (enq) tail_reg <= tail_reg + AW'(1);
      if (pop) head_reg <= head_reg + AW'(1);
      align_err_reg <= st_req && misaligned;
      if (st_req && misaligned) bad_addr_reg <= st_addr;
    end
  end

  // Entry storage needs no reset: validity comes solely from count and head.
  always_ff @(posedge clk) begin
    if (enq) begin
      waddr_mem[tail_reg] <= st_addr[31:2];
      be_mem[tail_reg]    <= enq_be;
      data_mem[tail_reg]  <= enq_data;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] age;
      assign age     = AW'(gi) - head_reg;
      assign hit[gi] = ({1'b0, age} < count_reg) && (waddr_mem[gi] == ld_addr[31:2]);
    end
  endgenerate

  assign ld_stall       = ld_check && (|hit);
  assign unused_ld_lsbs = ^ld_addr[1:0];

  assign mem_addr   = mem_req ? {waddr_mem[head_reg], 2'b00} : 32'h0;
  assign mem_byteen = mem_req ? be_mem[head_reg] : 4'b0000;
  assign mem_wdata  = mem_req ? data_mem[head_reg] : 32'h0;
  assign align_err  = align_err_reg;
  assign bad_addr   = bad_addr_reg;
  assign count      = count_reg;
endmodule

// File: tb/tb_m_store_buffer.sv
// Self-checking bench for m_store_buffer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_m_store_buffer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        align_err;
  logic [31:0] bad_addr;
  logic [$clog2(DEPTH):0] count;

  m_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .align_err(align_err), .bad_addr(bad_addr), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_align;
  logic [31:0] m_bad;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_stall();
    if (!ld_check) return 1'b0;
    foreach (q[i]) if (q[i].addr == (ld_addr & ~32'h3)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_model();
    logic have;
    have = (q.size() != 0);
    check("count",     32'(count),      32'(q.size()));
    check("st_ready",  32'(st_ready),   32'(q.size() < DEPTH));
    check("mem_req",   32'(mem_req),    32'(have));
    check("mem_addr",  mem_addr,        have ? q[0].addr : 32'h0);
    check("mem_byteen",32'(mem_byteen), have ? 32'(q[0].be) : 32'h0);
    check("mem_wdata", mem_wdata,       have ? q[0].data : 32'h0);
    check("ld_stall",  32'(ld_stall),   32'(exp_stall()));
    check("align_err", 32'(align_err),  32'(m_align));
    check("bad_addr",  bad_addr,        m_bad);
  endtask

  // Next-state of the reference model from the inputs present this cycle.
  task automatic model_step();
    logic is_req, mis, acc, pop;
    ent_t e;
    if (reset) begin
      q.delete();
      m_align = 1'b0;
      m_bad   = 32'h0;
      return;
    end
    is_req = st_valid && (st_op != 2'd0);
    case (st_op)
      2'd1:    mis = (st_addr % 4) != 0;
      2'd2:    mis = (st_addr % 2) != 0;
      default: mis = 1'b0;
    endcase
    acc = is_req && !mis && (q.size() < DEPTH);
    pop = (q.size() > 0) && mem_ack;
    m_align = is_req && mis;
    if (m_align) m_bad = st_addr;
    e.addr = st_addr & ~32'h3;
    case (st_op)
      2'd1: begin e.be = 4'hF; e.data = st_data; end
      2'd2: begin e.be = ((st_addr % 4) >= 2) ? 4'hC : 4'h3; e.data = 32'h00010001 * st_data[15:0]; end
      default: begin e.be = 4'(1 << (st_addr % 4)); e.data = 32'h01010101 * st_data[7:0]; end
    endcase
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(e);
  endtask

  task automatic tick();
    #3;
    compare_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic ack);
    st_valid = v; st_op = op; st_addr = a; st_data = d; mem_ack = ack; ld_check = 1'b0;
    tick();
  endtask

  task automatic idle(input logic ack);
    drive(1'b0, 2'd0, 32'h0, 32'h0, ack);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    reset = 1'b1; st_valid = 1'b0; st_op = 2'd0; st_addr = 32'h0; st_data = 32'h0;
    mem_ack = 1'b0; ld_check = 1'b0; ld_addr = 32'h0;
    q.delete(); m_align = 1'b0; m_bad = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst_count", 32'(count), 32'h0);
    check("rst_st_ready", 32'(st_ready), 32'h1);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_byteen", 32'(mem_byteen), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_align_err", 32'(align_err), 32'h0);
    check("rst_bad_addr", bad_addr, 32'h0);
    ld_check = 1'b1; #1;
    check("rst_ld_stall", 32'(ld_stall), 32'h0);
    ld_check = 1'b0;

    // Lane formatting, each store popped as the next one arrives.
    drive(1'b1, 2'd3, 32'h13, 32'h000000AB, 1'b1);
    check("sb_req", 32'(mem_req), 32'h1);
    check("sb_addr", mem_addr, 32'h10);
    check("sb_be", 32'(mem_byteen), 32'h8);
    check("sb_data", mem_wdata, 32'hABABABAB);
    drive(1'b1, 2'd2, 32'h12, 32'h00001234, 1'b1);
    check("sh_addr", mem_addr, 32'h10);
    check("sh_be", 32'(mem_byteen), 32'hC);
    check("sh_data", mem_wdata, 32'h12341234);
    drive(1'b1, 2'd1, 32'h20, 32'hDEADBEEF, 1'b1);
    check("sw_addr", mem_addr, 32'h20);
    check("sw_be", 32'(mem_byteen), 32'hF);
    check("sw_data", mem_wdata, 32'hDEADBEEF);
    idle(1'b1);
    check("lanes_drained", 32'(count), 32'h0);

    // Misaligned stores are reported, never queued.
    drive(1'b1, 2'd1, 32'h21, 32'h11111111, 1'b0);
    check("mis1_err", 32'(align_err), 32'h1);
    check("mis1_bad", bad_addr, 32'h21);
    check("mis1_count", 32'(count), 32'h0);
    drive(1'b1, 2'd2, 32'h33, 32'h22222222, 1'b0);
    check("mis2_err", 32'(align_err), 32'h1);
    check("mis2_bad", bad_addr, 32'h33);
    check("mis2_count", 32'(count), 32'h0);
    idle(1'b0);
    check("mis_clear", 32'(align_err), 32'h0);

    // Full buffer drops the third store until it is re-presented.
    drive(1'b1, 2'd1, 32'h100, 32'hA0000001, 1'b0);
    drive(1'b1, 2'd1, 32'h104, 32'hA0000002, 1'b0);
    drive(1'b1, 2'd1, 32'h108, 32'hA0000003, 1'b0);
    check("full_count", 32'(count), 32'h2);
    check("full_ready", 32'(st_ready), 32'h0);
    check("full_head", mem_addr, 32'h100);
    idle(1'b1);
    check("ack1_count", 32'(count), 32'h1);
    check("ack1_head", mem_addr, 32'h104);
    drive(1'b1, 2'd1, 32'h108, 32'hA0000003, 1'b0);
    check("repres_count", 32'(count), 32'h2);
    idle(1'b1);
    check("order3_addr", mem_addr, 32'h108);
    check("order3_data", mem_wdata, 32'hA0000003);
    idle(1'b1);
    check("full_drained", 32'(count), 32'h0);

    // Simultaneous enqueue and pop across pointer wrap.
    drive(1'b1, 2'd1, 32'h200, 32'h5A5A5A5A, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(4 * (i + 1));
      d = $urandom;
      drive(1'b1, 2'd1, a, d, 1'b1);
      check("sim_count", 32'(count), 32'h1);
      check("sim_addr", mem_addr, a);
      check("sim_data", mem_wdata, d);
    end
    idle(1'b1);

    // Load conflict against a buffered word.
    drive(1'b1, 2'd1, 32'h40, 32'h0BADF00D, 1'b0);
    st_valid = 1'b0; ld_check = 1'b1; ld_addr = 32'h42; #1;
    check("ld_hit", 32'(ld_stall), 32'h1);
    ld_addr = 32'h44; #1;
    check("ld_miss", 32'(ld_stall), 32'h0);
    tick();
    idle(1'b1);
    ld_check = 1'b1; ld_addr = 32'h42; #1;
    check("ld_after_ack", 32'(ld_stall), 32'h0);
    tick();

    // Reset while two entries are pending and an alignment error is showing.
    drive(1'b1, 2'd1, 32'h300, 32'h33333333, 1'b0);
    drive(1'b1, 2'd1, 32'h304, 32'h44444444, 1'b0);
    drive(1'b1, 2'd1, 32'h301, 32'h55555555, 1'b0);
    check("pre_rst_req", 32'(mem_req), 32'h1);
    check("pre_rst_err", 32'(align_err), 32'h1);
    reset = 1'b1;
    idle(1'b1);
    reset = 1'b0;
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_ready", 32'(st_ready), 32'h1);
    check("mid_rst_err", 32'(align_err), 32'h0);
    idle(1'b1);
    check("post_rst_req", 32'(mem_req), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      st_valid = $urandom_range(0, 1) == 1;
      st_op    = 2'($urandom_range(0, 3));
      st_addr  = 32'($urandom_range(0, 63));
      st_data  = $urandom;
      mem_ack  = ($urandom_range(0, 2) != 0);
      ld_check = $urandom_range(0, 1) == 1;
      ld_addr  = 32'($urandom_range(0, 63));
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
